// File: rtl/dnn_host_sequencer.sv
// Host-side traffic generator and result checker for dnn_accelerator bring-up/BIST.
// Streams deterministic MAC requests, triggers block reads and scores every returned word.
module dnn_host_sequencer #(
  parameter int ITERS     = 8,
  parameter int VEC_COUNT = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        EN_mac,
  input  logic        RDY_mac,
  output logic [15:0] mac_vectA_0,
  output logic [15:0] mac_vectA_1,
  output logic [15:0] mac_vectA_2,
  output logic [15:0] mac_vectA_3,
  output logic [15:0] mac_vectB_0,
  output logic [15:0] mac_vectB_1,
  output logic [15:0] mac_vectB_2,
  output logic [15:0] mac_vectB_3,
  output logic        EN_blockRead,
  input  logic        RDY_blockRead,
  input  logic        VALID_memVal,
  input  logic [33:0] memVal_data,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [5:0]  first_err_idx,
  output logic [3:0]  iter_count
);
  localparam int IW = $clog2(VEC_COUNT);
  localparam int KW = $clog2(ITERS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_RD, READ_REQ, COLLECT, NEXT, DONE} state_t;

  state_t        state, stateNext;
  logic [IW-1:0] reqIdx, wordIdx;
  logic [KW-1:0] iterIdx, nextK;
  logic [WW-1:0] wdCount;
  logic [15:0]   vectA [4];
  logic [15:0]   vectB [4];
  logic          xfer, lastReq, lastWord, lastIter, wdActive, wdHit, abort, mismatch;
  logic [33:0]   expected;

  // Exact 34-bit dot product of the operand pattern for request j of iteration k.
  function automatic logic [33:0] expVal(input logic [IW-1:0] j, input logic [KW-1:0] k);
    logic [15:0] a, b;
    logic [33:0] sum;
    sum = '0;
    for (int n = 0; n < 4; n++) begin
      a   = 16'(j) + 16'(k) * 16'd64 + 16'(n + 1);
      b   = 16'(j) + 16'(k) + 16'(n + 1);
      sum = sum + 34'(32'(a) * 32'(b));
    end
    return sum;
  endfunction

  assign mac_vectA_0 = vectA[0];
  assign mac_vectA_1 = vectA[1];
  assign mac_vectA_2 = vectA[2];
  assign mac_vectA_3 = vectA[3];
  assign mac_vectB_0 = vectB[0];
  assign mac_vectB_1 = vectB[1];
  assign mac_vectB_2 = vectB[2];
  assign mac_vectB_3 = vectB[3];

  assign xfer     = (state == ISSUE) && RDY_mac;
  assign lastReq  = reqIdx == IW'(VEC_COUNT - 1);
  assign lastWord = wordIdx == IW'(VEC_COUNT - 1);
  assign lastIter = iterIdx == KW'(ITERS - 1);
  assign nextK    = iterIdx + 1'b1;
  assign wdActive = (state inside {DRAIN, WAIT_RD, COLLECT}) || ((state == ISSUE) && !RDY_mac);
  assign wdHit    = wdActive && (wdCount == WW'(TIMEOUT - 1));
  assign expected = expVal(wordIdx, iterIdx);
  assign mismatch = memVal_data != expected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Normal progress wins over a watchdog expiry landing in the same cycle.
  always_comb begin
    stateNext    = state;
    EN_mac       = 1'b0;
    EN_blockRead = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE, DONE: if (start) stateNext = ISSUE;
      ISSUE: begin
        EN_mac = 1'b1;
        if (xfer && lastReq) stateNext = DRAIN;
        else if (wdHit)      abort = 1'b1;
      end
      DRAIN: begin
        if (!RDY_mac)   stateNext = WAIT_RD;
        else if (wdHit) abort = 1'b1;
      end
      WAIT_RD: begin
        if (RDY_blockRead) stateNext = READ_REQ;
        else if (wdHit)    abort = 1'b1;
      end
      READ_REQ: begin
        EN_blockRead = 1'b1;
        stateNext    = COLLECT;
      end
      COLLECT: begin
        if (VALID_memVal && lastWord) stateNext = NEXT;
        else if (wdHit)               abort = 1'b1;
      end
      NEXT:    stateNext = lastIter ? DONE : ISSUE;
      default: stateNext = IDLE;
    endcase
    if (abort) stateNext = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqIdx        <= '0;
      wordIdx       <= '0;
      iterIdx       <= '0;
      wdCount       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      error_count   <= '0;
      first_err_idx <= '0;
      iter_count    <= '0;
      for (int n = 0; n < 4; n++) begin
        vectA[n] <= '0;
        vectB[n] <= '0;
      end
    end else begin
      if (stateNext != state || xfer) wdCount <= '0;
      else if (wdActive)              wdCount <= wdCount + 1'b1;

      case (state)
        IDLE, DONE: if (start) begin
          reqIdx        <= '0;
          wordIdx       <= '0;
          iterIdx       <= '0;
          busy          <= 1'b1;
          done          <= 1'b0;
          timeout       <= 1'b0;
          error_count   <= '0;
          first_err_idx <= '0;
          iter_count    <= '0;
          for (int n = 0; n < 4; n++) begin
            vectA[n] <= 16'(n + 1);
            vectB[n] <= 16'(n + 1);
          end
        end
        ISSUE: if (xfer) begin
          reqIdx <= lastReq ? '0 : reqIdx + 1'b1;
          for (int n = 0; n < 4; n++) begin
            vectA[n] <= vectA[n] + 16'd1;
            vectB[n] <= vectB[n] + 16'd1;
          end
        end
        COLLECT: if (VALID_memVal) begin
          if (mismatch) begin
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (error_count == 16'd0)    first_err_idx <= 6'(wordIdx);
          end
          wordIdx <= lastWord ? '0 : wordIdx + 1'b1;
        end
        NEXT: begin
          iterIdx    <= nextK;
          iter_count <= iter_count + 4'd1;
          wordIdx    <= '0;
          for (int n = 0; n < 4; n++) begin
            vectA[n] <= 16'(nextK) * 16'd64 + 16'(n + 1);
            vectB[n] <= 16'(nextK) + 16'(n + 1);
          end
          if (lastIter) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (abort) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end
endmodule
